// File: rtl/ov9281_dvp_pkg.sv
// Shared definitions for the synthetic OV9281 DVP source.
// Holds the FSM states, the test-pattern codes and the 1280x800 default timing.
package ov9281_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VFRONT
    } dvp_state_e;

    localparam logic [1:0] PAT_HRAMP  = 2'd0;
    localparam logic [1:0] PAT_VRAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK  = 2'd2;
    localparam logic [1:0] PAT_STREAM = 2'd3;

    localparam int DEF_H_ACTIVE  = 1280;
    localparam int DEF_H_BLANK   = 64;
    localparam int DEF_V_ACTIVE  = 800;
    localparam int DEF_VSYNC_LEN = 16;
    localparam int DEF_V_BACK    = 32;
    localparam int DEF_V_FRONT   = 32;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov9281_dvp_tx_if.sv
// DVP output bus: frame sync, line valid and the href-qualified pixel byte.
interface ov9281_dvp_tx_if;
    logic       camera_vsync;
    logic       camera_href;
    logic [7:0] camera_data;

    modport master (output camera_vsync, camera_href, camera_data);
    modport slave  (input  camera_vsync, camera_href, camera_data);
endinterface

// File: rtl/dvp_pattern_gen.sv
// Combinational test-pattern byte generator; the caller registers the result.
module dvp_pattern_gen
    import ov9281_dvp_pkg::*;
(
    input  logic [1:0] pattern_sel,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] s,
    output logic [7:0] pix_o
);

    always_comb begin
        pix_o = x;
        case (pattern_sel)
            PAT_HRAMP:  pix_o = x;
            PAT_VRAMP:  pix_o = y;
            PAT_CHECK:  pix_o = {8{x[3] ^ y[3]}};
            PAT_STREAM: pix_o = s;
            default:    pix_o = x;
        endcase
    end

endmodule

// File: rtl/ov9281_dvp_tx.sv
// Synthetic OV9281 DVP source: frame/line timing FSM with registered outputs.
// Next-state counter values feed the pattern generator so data lines up with href.
module ov9281_dvp_tx
    import ov9281_dvp_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_BLANK   = DEF_H_BLANK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int VSYNC_LEN = DEF_VSYNC_LEN,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_FRONT   = DEF_V_FRONT
) (
    input  logic                    camera_pclk,
    input  logic                    CAMERA_RSTN,
    input  logic                    enable,
    input  logic [1:0]              pattern_sel,
    ov9281_dvp_tx_if.master         dvp,
    output logic                    frame_start,
    output logic [15:0]             frame_cnt
);

    localparam int X_W   = $clog2(H_ACTIVE);
    localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int P_MAX = max_of(max_of(VSYNC_LEN, V_BACK), max_of(H_BLANK, V_FRONT));
    localparam int C_W   = (P_MAX > 1) ? $clog2(P_MAX) : 1;

    localparam logic [C_W-1:0] VS_LAST = C_W'(VSYNC_LEN - 1);
    localparam logic [C_W-1:0] VB_LAST = C_W'(V_BACK - 1);
    localparam logic [C_W-1:0] HB_LAST = C_W'(H_BLANK - 1);
    localparam logic [C_W-1:0] VF_LAST = C_W'(V_FRONT - 1);
    localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);

    dvp_state_e     state_q, state_d;
    logic [C_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [7:0]     s_q, s_d;
    logic [1:0]     pat_q, pat_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     data_q, data_d;
    logic           frame_start_q, frame_start_d;
    logic           start_frame;
    logic [7:0]     pix;

    dvp_pattern_gen u_pat (
        .pattern_sel (pat_q),
        .x           (8'(x_d)),
        .y           (8'(y_d)),
        .s           (s_d),
        .pix_o       (pix)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        s_d         = s_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: start_frame = enable;
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_VBACK;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + C_W'(1);
            end
            ST_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else cnt_d = cnt_q + C_W'(1);
            end
            ST_ACTIVE: begin
                // s_q is the stream value of the byte on the bus this cycle
                s_d = s_q + 8'd1;
                if (x_q == X_LAST) state_d = ST_HBLANK;
                else               x_d     = x_q + X_W'(1);
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (y_q < Y_LAST) begin
                        state_d = ST_ACTIVE;
                        x_d     = '0;
                        y_d     = y_q + Y_W'(1);
                    end else state_d = ST_VFRONT;
                end else cnt_d = cnt_q + C_W'(1);
            end
            ST_VFRONT: begin
                if (cnt_q == VF_LAST) begin
                    cnt_d = '0;
                    if (enable) start_frame = 1'b1;
                    else        state_d     = ST_IDLE;
                end else cnt_d = cnt_q + C_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_frame) begin
            state_d     = ST_VSYNC;
            cnt_d       = '0;
            x_d         = '0;
            y_d         = '0;
            s_d         = 8'd0;
            pat_d       = pattern_sel;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        frame_start_d = start_frame;
        vsync_d       = (state_d == ST_VSYNC);
        href_d        = (state_d == ST_ACTIVE);
        data_d        = href_d ? pix : 8'd0;
    end

    always_ff @(posedge camera_pclk or negedge CAMERA_RSTN) begin
        if (!CAMERA_RSTN) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            s_q           <= 8'd0;
            pat_q         <= 2'd0;
            frame_cnt_q   <= 16'd0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            s_q           <= s_d;
            pat_q         <= pat_d;
            frame_cnt_q   <= frame_cnt_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dvp.camera_vsync = vsync_q;
    assign dvp.camera_href  = href_q;
    assign dvp.camera_data  = data_q;
    assign frame_start      = frame_start_q;
    assign frame_cnt        = frame_cnt_q;

endmodule
